// File: rtl/instr_fetch_router_if.sv
// instr_fetch_router_if: core fetch, RAM fetch port, data-bus debug request and debug-memory slave signals.
interface instr_fetch_router_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        ram_req_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_rdata_i;
  logic        dbus_req_i;
  logic        dbus_we_i;
  logic [31:0] dbus_addr_i;
  logic [3:0]  dbus_be_i;
  logic [31:0] dbus_wdata_i;
  logic        dbus_gnt_o;
  logic        dbus_rvalid_o;
  logic [31:0] dbus_rdata_o;
  logic        dbg_req_o;
  logic        dbg_we_o;
  logic [31:0] dbg_addr_o;
  logic [3:0]  dbg_be_o;
  logic [31:0] dbg_wdata_o;
  logic [31:0] dbg_rdata_i;
  modport slave (
    input  instr_req_i, instr_addr_i, ram_rdata_i, dbus_req_i, dbus_we_i,
           dbus_addr_i, dbus_be_i, dbus_wdata_i, dbg_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o, ram_req_o,
           ram_addr_o, dbus_gnt_o, dbus_rvalid_o, dbus_rdata_o, dbg_req_o,
           dbg_we_o, dbg_addr_o, dbg_be_o, dbg_wdata_o
  );
  modport master (
    output instr_req_i, instr_addr_i, ram_rdata_i, dbus_req_i, dbus_we_i,
           dbus_addr_i, dbus_be_i, dbus_wdata_i, dbg_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o, ram_req_o,
           ram_addr_o, dbus_gnt_o, dbus_rvalid_o, dbus_rdata_o, dbg_req_o,
           dbg_we_o, dbg_addr_o, dbg_be_o, dbg_wdata_o
  );
endinterface

// File: rtl/instr_fetch_router.sv
// instr_fetch_router: routes fetches to RAM or debug memory, arbitrating the debug port
// against data-bus requests with a starvation-bounded fixed priority.
module instr_fetch_router #(
  parameter logic [31:0] RamBase = 32'h00100000,
  parameter logic [31:0] RamMask = 32'hFFFF0000,
  parameter logic [31:0] DbgBase = 32'h1A110000,
  parameter logic [31:0] DbgMask = 32'hFFFF0000,
  parameter int unsigned MaxWait = 3
) (
  input logic clk_i,
  input logic rst_ni,
  instr_fetch_router_if.slave bus
);
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_RAM  = 2'd1;
  localparam logic [1:0] SRC_DBG  = 2'd2;
  localparam logic [1:0] SRC_ERR  = 2'd3;
  localparam logic [3:0] MW = 4'(MaxWait);
  logic       hit_ram, hit_dbg, f_ram, f_dbg, f_err, fetch_win, data_win;
  logic [3:0] cnt;
  logic [1:0] src;
  assign hit_ram   = (bus.instr_addr_i & RamMask) == RamBase;
  assign hit_dbg   = (bus.instr_addr_i & DbgMask) == DbgBase;
  assign f_ram     = bus.instr_req_i & hit_ram;
  assign f_dbg     = bus.instr_req_i & hit_dbg & ~hit_ram;
  assign f_err     = bus.instr_req_i & ~hit_ram & ~hit_dbg;
  // Data normally wins the debug port; a fetch that has lost MaxWait times in a row takes it.
  assign fetch_win = f_dbg & (~bus.dbus_req_i | (cnt == MW));
  assign data_win  = bus.dbus_req_i & ~fetch_win;
  assign bus.instr_gnt_o    = f_ram | f_err | fetch_win;
  assign bus.dbus_gnt_o     = data_win;
  assign bus.ram_req_o      = f_ram;
  assign bus.ram_addr_o     = bus.instr_addr_i;
  assign bus.dbg_req_o      = fetch_win | data_win;
  assign bus.dbg_we_o       = fetch_win ? 1'b0 : bus.dbus_we_i;
  assign bus.dbg_addr_o     = fetch_win ? bus.instr_addr_i : bus.dbus_addr_i;
  assign bus.dbg_be_o       = fetch_win ? 4'hF : bus.dbus_be_i;
  assign bus.dbg_wdata_o    = fetch_win ? 32'h0 : bus.dbus_wdata_i;
  assign bus.instr_rvalid_o = src != SRC_NONE;
  assign bus.instr_err_o    = src == SRC_ERR;
  assign bus.instr_rdata_o  = src == SRC_RAM ? bus.ram_rdata_i :
                              src == SRC_DBG ? bus.dbg_rdata_i : 32'h0;
  assign bus.dbus_rdata_o   = bus.dbg_rdata_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt               <= '0;
      src               <= SRC_NONE;
      bus.dbus_rvalid_o <= 1'b0;
    end else begin
      cnt               <= (f_dbg && !fetch_win) ? ((cnt == MW) ? cnt : cnt + 4'd1) : '0;
      src               <= f_ram ? SRC_RAM : fetch_win ? SRC_DBG : f_err ? SRC_ERR : SRC_NONE;
      bus.dbus_rvalid_o <= data_win;
    end
endmodule
